uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel front end for the CPU's serial_in line: recovers 8N1 UART frames
//  (1 start, 8 data LSB-first, 1 stop) and presents each byte on a ready/valid port.
//  The CPU's UART MMIO read path pops that port. The assembly/ISA benches drive serial_in.
//  Idles on a high line.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  clk frequency in Hz (the 20 ns CPU clock)
//  BAUD_RATE   115_200     line rate in bits/s
//  derived: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (434); SAMPLE_TIME = SYMBOL_EDGE_TIME/2;
//  counter width = $clog2(SYMBOL_EDGE_TIME)
// PORTS
//  clk             in   1  single clock, rising-edge
//  rst             in   1  asynchronous, active-high reset
//  serial_in       in   1  asynchronous UART line; idle = 1
//  data_out        out  8  received byte; stable while data_out_valid=1
//  data_out_valid  out  1  byte available
//  data_out_ready  in   1  consumer accepts; transfer when valid&ready at posedge clk
//  framing_error   out  1  one-cycle pulse: stop bit sampled 0
//  overrun         out  1  one-cycle pulse: completed byte dropped because holding reg full
// BEHAVIOUR
//  Reset (async, while rst=1): state=IDLE; counters=0; both synchroniser flops=1;
//   data_out=0; data_out_valid=0; framing_error=0; overrun=0.
//   Reset mid-frame aborts the frame; no byte is produced for it.
//  serial_in passes through a 2-flop synchroniser; all decisions use the synced line (rx).
//  FSM:
//   IDLE:  rx==0 -> START, cnt=0.
//   START: cnt counts to SAMPLE_TIME-1. Then rx==1 -> IDLE (glitch, no output).
//          rx==0 -> DATA, cnt=0, bit_idx=0.
//   DATA:  every SYMBOL_EDGE_TIME cycles, shift rx into shift[7] (LSB-first fill),
//          bit_idx++. After bit 7 -> STOP, cnt=0.
//   STOP:  after SYMBOL_EDGE_TIME cycles, sample rx.
//          rx==1 -> deliver the byte (below), then IDLE.
//          rx==0 -> framing_error=1 for 1 cycle, byte discarded, then BREAK.
//   BREAK: wait for rx==1, then IDLE. This prevents a held-low line from retriggering.
//  All samples fall at mid-bit.
//  Latency: the stop-bit sample falls 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME cycles after the
//   serial_in falling edge. data_out_valid rises the next cycle.
//  Deliver:
//   if !data_out_valid, or data_out_valid & data_out_ready in the same cycle:
//     data_out<=shift, data_out_valid<=1.
//   else: data_out/valid unchanged, overrun=1 for 1 cycle, new byte lost.
//  Handshake: data_out_valid stays 1 until a cycle with data_out_ready=1, then clears
//   (unless a new byte is delivered in that same cycle).
//   data_out_ready while !valid has no effect. valid never depends combinationally on ready.
//  Next frame: the receiver is in IDLE one cycle after the stop sample. A start bit
//   immediately after the stop bit is accepted (back-to-back frames, no idle gap needed).
//  framing_error and overrun are mutually exclusive per frame. They never assert together.
// TESTING
//  (CLOCK_FREQ=50e6, BAUD_RATE=115200, 434 clk/bit)
//  1. Send 0xA5 with ready=0 -> data_out_valid rises 2+217+9*434+1=4126 cycles after the
//     start edge, data_out=8'hA5, stays valid. Then ready=1 for 1 cycle -> valid=0.
//  2. Drive serial_in low for 100 cycles, then high -> valid, framing_error and overrun
//     stay 0; FSM returns to IDLE.
//  3. Send 0x00 then 0xFF back-to-back, no idle gap, ready=1 -> two valid cycles, with
//     data_out 8'h00 then 8'hFF; no errors.
//  4. ready=0, send 0x3C then 0xC3 -> data_out stays 8'h3C, overrun pulses once at the
//     second stop sample. Then ready=1 -> 0x3C consumed; 0xC3 is never delivered.
//  5. Frame 0x55 with stop bit 0, line held low 2 bit-times -> framing_error pulses once,
//     valid stays 0. After the line returns high, a following 0x12 is received correctly.
//  6. Assert rst during data bit 4 of 0x7E -> all outputs 0 immediately (async).
//     Release rst, send 0x81 -> data_out=8'h81; no stale bits from the aborted frame.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Byte-output port of the UART receiver: ready/valid data plus one-cycle error pulses.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  modport master (
    output data_out,
    output data_out_valid,
    output framing_error,
    output overrun,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  framing_error,
    input  overrun,
    output data_out_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-byte holding register.
// Stop sample lands 2+SAMPLE_TIME+9*SYMBOL_EDGE_TIME cycles after the start edge; a byte arriving while the holding register is full is dropped with an overrun pulse.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  uart_receiver_if.master rx_if
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          sync_q, rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      sync_q    <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      sync_q    <= serial_in;
      rx_q      <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_if.data_out_ready;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d = '0;
          if (rx_q) begin
            state_d = IDLE;
            // A slot frees up if the held byte is being popped this very cycle.
            if (!valid_q || rx_if.data_out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign rx_if.framing_error  = fe_q;
  assign rx_if.overrun        = ov_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: randomized frames checked against a frame-level model.
module tb_uart_receiver;
  localparam int BIT = 434;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  int   checks = 0;
  int   failures = 0;

  uart_receiver_if u_if ();

  uart_receiver #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rx_if     (u_if)
  );

  always #10 clk = ~clk;

  // Monitor: observes transfers and pulses mid-cycle.
  logic [7:0] got_q[$];
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.data_out_valid && u_if.data_out_ready) got_q.push_back(u_if.data_out);
      if (u_if.framing_error) fe_cnt++;
      if (u_if.overrun) ov_cnt++;
      if (u_if.framing_error && u_if.overrun) both_cnt++;
    end
  end

  // Frame-level reference: good frames are delivered when the consumer is ready;
  // otherwise the first one is held and later good ones are lost as overruns.
  logic [7:0] sent_q[$];
  bit         stop_q[$];
  logic [7:0] exp_q[$];
  int exp_fe, exp_ov;
  task automatic model_run(input bit rdy);
    bit held = 0;
    exp_q.delete(); exp_fe = 0; exp_ov = 0;
    foreach (sent_q[i]) begin
      if (!stop_q[i]) exp_fe++;
      else if (rdy) exp_q.push_back(sent_q[i]);
      else if (!held) begin exp_q.push_back(sent_q[i]); held = 1; end
      else exp_ov++;
    end
    sent_q.delete(); stop_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    sent_q.push_back(b); stop_q.push_back(stop_bit);
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      cycles(BIT);
    end
    serial_in = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; u_if.data_out_ready = 1'b0;
    cycles(3);
    checks++; if (u_if.data_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", u_if.data_out_valid); end
    checks++; if (u_if.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", u_if.data_out); end
    checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", u_if.framing_error); end
    checks++; if (u_if.overrun !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", u_if.overrun); end
    @(negedge clk); rst = 1'b0;
    cycles(5);
  endtask

  task automatic test_latency;
    int n = 0;
    int base = got_q.size();
    u_if.data_out_ready = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (u_if.data_out_valid !== 1'b1 && n < 5000) begin cycles(1); n++; end
      end
    join
    model_run(1'b0);
    checks++; if (n !== 4126) begin failures++; $display("FAIL latency got=%0d exp=4126", n); end
    checks++; if (u_if.data_out !== exp_q[0]) begin failures++; $display("FAIL latency_data got=%h exp=%h", u_if.data_out, exp_q[0]); end
    cycles(50);
    checks++; if (u_if.data_out_valid !== 1'b1 || u_if.data_out !== exp_q[0]) begin failures++; $display("FAIL hold_valid got=%b/%h exp=1/%h", u_if.data_out_valid, u_if.data_out, exp_q[0]); end
    u_if.data_out_ready = 1'b1; cycles(1); u_if.data_out_ready = 1'b0;
    checks++; if (u_if.data_out_valid !== 1'b0) begin failures++; $display("FAIL pop_clears got=%b exp=0", u_if.data_out_valid); end
    checks++; if (got_q.size() - base !== 1) begin failures++; $display("FAIL pop_count got=%0d exp=1", got_q.size() - base); end
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt, ov0 = ov_cnt, base = got_q.size();
    logic [7:0] r = 8'($urandom_range(0, 255));
    serial_in = 1'b0; cycles(100); serial_in = 1'b1; cycles(600);
    sent_q.delete(); stop_q.delete();
    checks++; if (u_if.data_out_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", u_if.data_out_valid); end
    checks++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin failures++; $display("FAIL glitch_err got fe=%0d ov=%0d exp 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    u_if.data_out_ready = 1'b1;
    send_frame(r, 1'b1);
    cycles(20);
    u_if.data_out_ready = 1'b0;
    model_run(1'b1);
    checks++; if (got_q.size() - base !== 1 || got_q[base] !== exp_q[0]) begin failures++; $display("FAIL after_glitch got_n=%0d exp=%h", got_q.size() - base, exp_q[0]); end
  endtask

  task automatic test_back_to_back;
    int fe0 = fe_cnt, ov0 = ov_cnt, base = got_q.size();
    u_if.data_out_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    cycles(20);
    u_if.data_out_ready = 1'b0;
    model_run(1'b1);
    checks++; if (got_q.size() - base !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        checks++; if (got_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
      end
    end
    checks++; if (fe_cnt - fe0 !== exp_fe || ov_cnt - ov0 !== exp_ov) begin failures++; $display("FAIL b2b_err got fe=%0d ov=%0d exp %0d/%0d", fe_cnt - fe0, ov_cnt - ov0, exp_fe, exp_ov); end
  endtask

  task automatic test_overrun;
    int fe0 = fe_cnt, ov0 = ov_cnt, base = got_q.size();
    u_if.data_out_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    cycles(20);
    model_run(1'b0);
    checks++; if (u_if.data_out !== exp_q[0] || u_if.data_out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold got=%b/%h exp=1/%h", u_if.data_out_valid, u_if.data_out, exp_q[0]); end
    checks++; if (ov_cnt - ov0 !== exp_ov || fe_cnt - fe0 !== exp_fe) begin failures++; $display("FAIL ovr_pulse got ov=%0d fe=%0d exp %0d/%0d", ov_cnt - ov0, fe_cnt - fe0, exp_ov, exp_fe); end
    u_if.data_out_ready = 1'b1; cycles(1); u_if.data_out_ready = 1'b0;
    cycles(10);
    checks++; if (got_q.size() - base !== 1 || got_q[base] !== exp_q[0] || u_if.data_out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got_n=%0d valid=%b exp 1/0", got_q.size() - base, u_if.data_out_valid); end
  endtask

  task automatic test_framing;
    int fe0 = fe_cnt, ov0 = ov_cnt, base = got_q.size();
    logic [7:0] r = 8'($urandom_range(0, 255));
    u_if.data_out_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    serial_in = 1'b0; cycles(2 * BIT); serial_in = 1'b1; cycles(10);
    checks++; if (fe_cnt - fe0 !== 1 || u_if.data_out_valid !== 1'b0 || got_q.size() !== base) begin failures++; $display("FAIL frame_err got fe=%0d valid=%b exp 1/0", fe_cnt - fe0, u_if.data_out_valid); end
    send_frame(8'h12, 1'b1);
    send_frame(r, 1'b1);
    cycles(20);
    u_if.data_out_ready = 1'b0;
    model_run(1'b1);
    checks++; if (fe_cnt - fe0 !== exp_fe || ov_cnt - ov0 !== exp_ov) begin failures++; $display("FAIL frame_counts got fe=%0d ov=%0d exp %0d/%0d", fe_cnt - fe0, ov_cnt - ov0, exp_fe, exp_ov); end
    checks++; if (got_q.size() - base !== 2 || got_q[base] !== exp_q[0] || got_q[base + 1] !== exp_q[1]) begin failures++; $display("FAIL frame_recover got_n=%0d exp=%h,%h", got_q.size() - base, exp_q[0], exp_q[1]); end
  endtask

  task automatic test_reset_mid_frame;
    int fe0 = fe_cnt, base;
    logic [7:0] r = 8'($urandom_range(0, 255));
    u_if.data_out_ready = 1'b0;
    send_frame(r, 1'b1);
    cycles(5);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        cycles(2300);
        rst = 1'b1; #1;
        checks++; if (u_if.data_out_valid !== 1'b0 || u_if.data_out !== 8'h00 || u_if.framing_error !== 1'b0 || u_if.overrun !== 1'b0) begin failures++; $display("FAIL async_reset got valid=%b data=%h exp 0/00", u_if.data_out_valid, u_if.data_out); end
      end
    join
    sent_q.delete(); stop_q.delete();
    rst = 1'b0;
    cycles(5);
    base = got_q.size();
    u_if.data_out_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    cycles(20);
    u_if.data_out_ready = 1'b0;
    model_run(1'b1);
    checks++; if (got_q.size() - base !== 1 || got_q[base] !== exp_q[0] || fe_cnt !== fe0) begin failures++; $display("FAIL post_reset got_n=%0d exp=%h", got_q.size() - base, exp_q[0]); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL err_exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    u_if.data_out_ready = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
